// File: rtl/alu_seq_pkg.sv
// alu_seq shared types: op codes, FSM states, ALU control word.
// Optional zero flag: define ALU_SEQ_ZERO_FLAG_EN.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } AluOp;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic       b_inv;
    logic       carry_disable;
    logic [1:0] cmd;
  } AluCtrl;

  localparam logic SUB_CARRY_IN = 1'b1;

  function automatic AluCtrl op_to_ctrl(AluOp op);
    AluCtrl c;
    c = '0;
    unique case (op)
      OP_ADD: c = '{b_inv: 1'b0, carry_disable: 1'b0, cmd: 2'd0};
      OP_SUB: c = '{b_inv: 1'b1, carry_disable: 1'b0, cmd: 2'd0};
      OP_AND: c = '{b_inv: 1'b0, carry_disable: 1'b1, cmd: 2'd1};
      OP_OR:  c = '{b_inv: 1'b0, carry_disable: 1'b1, cmd: 2'd2};
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between control logic and alu_seq.
// Carries zero only when ALU_SEQ_ZERO_FLAG_EN is defined.
interface alu_seq_if
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  AluOp         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic         zero;
`endif

  modport master (
    output start, op, a, b,
    input  ready, done, result, carry_out
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , input zero
`endif
  );

  modport slave (
    input  start, op, a, b,
    output ready, done, result, carry_out
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , output zero
`endif
  );

endinterface

// File: rtl/alu_seq_alu.sv
// Shared 4-bit ALU slice: add (with optional b invert), and, or.
// Carry is suppressed whenever carry_disable is set.
module alu
  import alu_seq_pkg::*;
(
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic       carry_in,
  input  AluCtrl     ctrl,
  output logic [3:0] res,
  output logic       carry_out
);

  logic [3:0] d2e;
  logic [4:0] sum;

  // combinational slice datapath
  always_comb begin
    d2e = ctrl.b_inv ? ~d2 : d2;
    sum = {1'b0, d1} + {1'b0, d2e}
        + {4'b0, carry_in & ~ctrl.carry_disable};
    res = sum[3:0];
    carry_out = 1'b0;
    case (ctrl.cmd)
      2'd0: begin
        res = sum[3:0];
        carry_out = sum[4] & ~ctrl.carry_disable;
      end
      2'd1: res = d1 & d2e;
      2'd2: res = d1 | d2e;
      default: res = sum[3:0];
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Wide op sequencer: runs the 4-bit alu one nibble per cycle, LSB first.
// Optional zero output: define ALU_SEQ_ZERO_FLAG_EN.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES + 1);

  state_t        state;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  AluOp          op_q;
  logic [IW-1:0] idx;
  logic          carry_q;

  AluCtrl        ctrl;
  logic [3:0]    alu_res;
  logic          alu_co;
  logic [W-1:0]  res_next;
  logic          accept;
  logic          last;

  assign ctrl   = op_to_ctrl(op_q);
  assign accept = bus.start & bus.ready;
  assign last   = (idx == IW'(NIBBLES - 1));

  alu u_alu (
    .d1        (a_sh[3:0]),
    .d2        (b_sh[3:0]),
    .carry_in  (carry_q),
    .ctrl      (ctrl),
    .res       (alu_res),
    .carry_out (alu_co)
  );

  // new nibble enters result from the MSB side
  if (NIBBLES == 1) begin : g_one
    assign res_next = alu_res;
  end else begin : g_many
    assign res_next = {alu_res, bus.result[W-1:4]};
  end

  // sequencer FSM with registered handshake and result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      a_sh          <= '0;
      b_sh          <= '0;
      op_q          <= OP_ADD;
      idx           <= '0;
      carry_q       <= 1'b0;
      bus.ready     <= 1'b1;
      bus.done      <= 1'b0;
      bus.result    <= '0;
      bus.carry_out <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      bus.zero      <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        state     <= S_RUN;
        bus.ready <= 1'b0;
        a_sh      <= bus.a;
        b_sh      <= bus.b;
        op_q      <= bus.op;
        idx       <= '0;
        carry_q   <= (bus.op == OP_SUB) ? SUB_CARRY_IN : 1'b0;
      end else if (state == S_RUN) begin
        bus.result <= res_next;
        a_sh       <= a_sh >> 4;
        b_sh       <= b_sh >> 4;
        carry_q    <= alu_co;
        idx        <= idx + 1'b1;
        if (last) begin
          state         <= S_DONE;
          bus.ready     <= 1'b1;
          bus.done      <= 1'b1;
          bus.carry_out <= alu_co;
`ifdef ALU_SEQ_ZERO_FLAG_EN
          bus.zero      <= (res_next == '0);
`endif
        end
      end else if (state == S_DONE) begin
        state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with NIBBLES=4.
// Checks zero too when ALU_SEQ_ZERO_FLAG_EN is defined.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_seq_if #(.NIBBLES(4)) bus ();

  alu_seq #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_op(
    input  AluOp        o,
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [15:0] r,
    output logic        c,
    output int          n,
    output int          rdy_hi
  );
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op = OP_OR;
    bus.a = 16'hDEAD;
    bus.b = 16'hBEEF;
    n = 0;
    rdy_hi = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        n = i;
        break;
      end
      if (bus.ready) rdy_hi++;
    end
    r = bus.result;
    c = bus.carry_out;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.op = OP_ADD;
    bus.a = '0;
    bus.b = '0;
    #12;
    checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs ready=%b done=%b want 1 0",
               bus.ready, bus.done);
    end
    checks++;
    if (bus.result !== 16'h0 || bus.carry_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_res result=%h co=%b want 0000 0",
               bus.result, bus.carry_out);
    end
`ifdef ALU_SEQ_ZERO_FLAG_EN
    checks++;
    if (bus.zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_zero got=%b want 0", bus.zero);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    logic [15:0] r;
    logic        c;
    int          n;
    int          rh;
    do_op(OP_ADD, 16'h1234, 16'h0FFF, r, c, n, rh);
    checks++;
    if (n !== 5) begin
      failures++;
      $display("FAIL add_latency got=%0d want 5", n);
    end
    checks++;
    if (rh !== 0) begin
      failures++;
      $display("FAIL add_ready_run ready_high=%0d want 0", rh);
    end
    checks++;
    if (r !== 16'h2233 || c !== 1'b0) begin
      failures++;
      $display("FAIL add_basic got=%h/%b want 2233/0", r, c);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.result !== 16'h2233) begin
      failures++;
      $display("FAIL add_pulse done=%b res=%h want 0 2233",
               bus.done, bus.result);
    end
    do_op(OP_ADD, 16'hFFFF, 16'h0001, r, c, n, rh);
    checks++;
    if (r !== 16'h0000 || c !== 1'b1 || n !== 5) begin
      failures++;
      $display("FAIL add_wrap got=%h/%b n=%0d want 0000/1 n=5",
               r, c, n);
    end
`ifdef ALU_SEQ_ZERO_FLAG_EN
    checks++;
    if (bus.zero !== 1'b1) begin
      failures++;
      $display("FAIL add_zero got=%b want 1", bus.zero);
    end
`endif
  endtask

  task automatic test_sub();
    logic [15:0] r;
    logic        c;
    int          n;
    int          rh;
    do_op(OP_SUB, 16'h0005, 16'h0007, r, c, n, rh);
    checks++;
    if (r !== 16'hFFFE || c !== 1'b0 || n !== 5) begin
      failures++;
      $display("FAIL sub_borrow got=%h/%b n=%0d want fffe/0 n=5",
               r, c, n);
    end
`ifdef ALU_SEQ_ZERO_FLAG_EN
    checks++;
    if (bus.zero !== 1'b0) begin
      failures++;
      $display("FAIL sub_zero got=%b want 0", bus.zero);
    end
`endif
    do_op(OP_SUB, 16'h1000, 16'h0001, r, c, n, rh);
    checks++;
    if (r !== 16'h0FFF || c !== 1'b1) begin
      failures++;
      $display("FAIL sub_noborrow got=%h/%b want 0fff/1", r, c);
    end
  endtask

  task automatic test_logic();
    logic [15:0] r;
    logic        c;
    int          n;
    int          rh;
    do_op(OP_ADD, 16'h8000, 16'h8000, r, c, n, rh);
    do_op(OP_AND, 16'hF0F0, 16'h3C3C, r, c, n, rh);
    checks++;
    if (r !== 16'h3030 || c !== 1'b0) begin
      failures++;
      $display("FAIL and_op got=%h/%b want 3030/0", r, c);
    end
    do_op(OP_OR, 16'hF0F0, 16'h3C3C, r, c, n, rh);
    checks++;
    if (r !== 16'hFCFC || c !== 1'b0 || n !== 5) begin
      failures++;
      $display("FAIL or_op got=%h/%b n=%0d want fcfc/0 n=5",
               r, c, n);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = OP_ADD;
    bus.a = 16'h1111;
    bus.b = 16'h2222;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = OP_OR;
    bus.a = 16'hAAAA;
    bus.b = 16'h5555;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    for (int i = 4; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n !== 5 || bus.result !== 16'h3333 || bus.carry_out !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first n=%0d res=%h co=%b want 5 3333 0",
               n, bus.result, bus.carry_out);
    end
    bus.start = 1'b1;
    bus.op = OP_SUB;
    bus.a = 16'h8000;
    bus.b = 16'h0001;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.ready !== 1'b0 || bus.result !== 16'h3333) begin
      failures++;
      $display("FAIL b2b_accept ready=%b res=%h want 0 3333",
               bus.ready, bus.result);
    end
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n !== 5 || bus.result !== 16'h7FFF || bus.carry_out !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second n=%0d res=%h co=%b want 5 7fff 1",
               n, bus.result, bus.carry_out);
    end
  endtask

  task automatic test_abort();
    logic [15:0] r;
    logic        c;
    int          n;
    int          rh;
    int          dn;
    do_op(OP_OR, 16'hF0F0, 16'h3C3C, r, c, n, rh);
    do_op(OP_ADD, 16'hFFFF, 16'h0001, r, c, n, rh);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = OP_OR;
    bus.a = 16'h1234;
    bus.b = 16'h4321;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.result !== 16'h0 || bus.carry_out !== 1'b0 ||
        bus.done !== 1'b0 || bus.ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_reset res=%h co=%b done=%b rdy=%b want 0 0 0 1",
               bus.result, bus.carry_out, bus.done, bus.ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    checks++;
    if (dn !== 0 || bus.ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_nodone done_count=%0d rdy=%b want 0 1",
               dn, bus.ready);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
